jkff_bank_ctrl: RTL and testbench
=================================

// Module: jkff_bank_ctrl
// PURPOSE
//  Sequencer for a bank of WIDTH jkff cells (sync active-low pr/cl, clear has priority over preset).
//  Accepts commands over a valid/ready handshake and drives per-bit j/k/pr/cl to the bank:
//  clear, preset, load, count up/down, toggle and hold.
//  Keeps a shadow copy of the bank state and flags any divergence from the bank's q feedback.
// PARAMETERS
//  WIDTH  4  number of jkff cells in the bank
//  CNT_W  8  width of the cmd_cnt step count
// PORTS
//  clk        in   1      single clock; bank and controller use the same posedge
//  rst        in   1      asynchronous, active-high reset
//  cmd_valid  in   1      command offered
//  cmd_ready  out  1      controller can accept a command
//  cmd_op     in   3      0 NOP, 1 CLEAR, 2 PRESET, 3 LOAD, 4 UP, 5 DOWN, 6 TOGGLE, 7 HOLD
//  cmd_data   in   WIDTH  LOAD value, or TOGGLE mask
//  cmd_cnt    in   CNT_W  step count for UP, DOWN and HOLD
//  jk_j       out  WIDTH  j inputs to the bank
//  jk_k       out  WIDTH  k inputs to the bank
//  jk_pr      out  1      preset to the bank, active low
//  jk_cl      out  1      clear to the bank, active low
//  q_fb       in   WIDTH  q outputs fed back from the bank
//  q_mirror   out  WIDTH  expected bank state
//  busy       out  1      command in progress
//  done       out  1      one-cycle pulse when a command completes
//  err        out  1      sticky mismatch flag: q_fb differs from q_mirror
// BEHAVIOUR
//  - Reset (async):
//    - state=IDLE, q_mirror=0, step counter=0, busy=0, done=0, err=0, cmd_ready=0.
//    - jk_cl=0 and jk_pr=1 while rst=1; jk_j=jk_k=0.
//    - The bank clears on every clock edge during reset. Reset must span at least one clk edge.
//  - Handshake: cmd_ready = (state==IDLE) & ~rst. Accept when cmd_valid & cmd_ready at a posedge.
//    - cmd_* are sampled into registers at accept; the inputs are don't-care afterwards.
//  - FSM states: IDLE, CLR, PRE, LOAD, STEP, TOG.
//    - On accept: op 1 -> CLR, 2 -> PRE, 3 -> LOAD, 6 -> TOG, 4/5/7 -> STEP with count=cmd_cnt.
//    - NOP, or UP/DOWN/HOLD with cmd_cnt=0: stay in IDLE, done=1 next cycle, no bank edge.
//  - Bank drive is a combinational decode of the registered state, q_mirror and command.
//    - IDLE: j=k=0, pr=cl=1 (bank holds).
//    - CLR: cl=0. PRE: pr=0. LOAD: j=data, k=~data. TOG: j=k=data.
//    - STEP, UP:   bit0 j=k=1; bit i j=k=&q_mirror[i-1:0].
//    - STEP, DOWN: bit0 j=k=1; bit i j=k=~|q_mirror[i-1:0].
//    - STEP, HOLD: j=k=0.
//  - q_mirror updates on the same edge the bank samples, to the value the bank must take.
//    - CLR -> 0. PRE -> all ones. LOAD -> data. TOG -> q_mirror^data. UP -> +1. DOWN -> -1.
//    - UP/DOWN arithmetic is modulo 2^WIDTH: all-ones+1 -> 0, 0-1 -> all-ones.
//  - Timing:
//    - CLR, PRE, LOAD and TOG take exactly one bank edge, the first edge after accept.
//    - STEP applies one bank edge per cycle and decrements the counter; it leaves on the edge where count reaches 1.
//    - An N-step command occupies N cycles with busy=1.
//    - On the final edge: state -> IDLE, done=1 for the following cycle only.
//    - A new command may be accepted in the done cycle; done and cmd_ready can be high together.
//  - Check:
//    - Every posedge with rst=0: if q_fb != q_mirror (pre-edge values), set err.
//    - err is cleared only by rst or by acceptance of a CLEAR command; the clear takes effect on the accept edge.
//    - err does not stop sequencing.
//  - Reset mid-command: aborts immediately to IDLE, remaining steps are discarded, no done pulse.
//  - Width rules: cmd_cnt is unsigned, max 2^CNT_W-1 steps. All outputs are WIDTH or 1 bit; no truncation warnings allowed.
// TESTING
//  - Use WIDTH=4. The bench instantiates 4 jkff cells driven by jk_*, with q_fb wired from them.
//  1 Reset: rst=1 for 2 edges -> jk_cl=0, q_fb=0000, q_mirror=0000, cmd_ready=0.
//    After release: cmd_ready=1, err=0.
//  2 LOAD data=1010 -> one cycle with j=1010, k=0101, then q_fb=q_mirror=1010.
//    done high exactly one cycle, busy high exactly one cycle.
//  3 LOAD 1110, then UP cnt=3 -> q sequence 1111, 0000, 0001 (wrap). busy for 3 cycles, then done, err=0.
//  4 CLEAR, then DOWN cnt=2 -> q sequence 1111, 1110. Then TOGGLE 0101 -> 1011. Then HOLD cnt=4 -> q stays 1011 for 4 cycles.
//  5 Bench forces q_fb[0] inverted for one cycle while IDLE -> err=1 from the next edge.
//    err persists through a LOAD; it clears on accept of CLEAR.
//  6 UP cnt=10 from 0000, assert rst after 4 steps -> q_mirror=0000 async, busy=0, no done pulse.
//    After release, a LOAD accepts on the first cycle.

Source files
------------

// File: rtl/jkff_bank_ctrl.sv
// jkff_bank_ctrl: command sequencer for a bank of WIDTH jk flip-flops.
// Takes one command at a time over a valid/ready handshake and decodes it into
// per-bit j/k plus bank-wide active-low preset/clear. It keeps a shadow copy of
// the state the bank should hold and raises a sticky flag on any divergence.
//
// Handshake: a command is accepted on a posedge where cmd_valid and cmd_ready are
// both high. cmd_ready is high only in IDLE and never while rst is high. The
// command fields are captured at accept, so the source may change them on the
// next cycle without waiting for done.
module jkff_bank_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_cnt,
    output logic [WIDTH-1:0] jk_j,
    output logic [WIDTH-1:0] jk_k,
    output logic             jk_pr,
    output logic             jk_cl,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] q_mirror,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [2:0]       dbg_state
);

    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_CLEAR  = 3'd1;
    localparam logic [2:0] OP_PRESET = 3'd2;
    localparam logic [2:0] OP_LOAD   = 3'd3;
    localparam logic [2:0] OP_UP     = 3'd4;
    localparam logic [2:0] OP_DOWN   = 3'd5;
    localparam logic [2:0] OP_TOGGLE = 3'd6;
    localparam logic [2:0] OP_HOLD   = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CLR  = 3'd1,
        S_PRE  = 3'd2,
        S_LOAD = 3'd3,
        S_STEP = 3'd4,
        S_TOG  = 3'd5
    } state_t;

    state_t           r_state;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_data;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_mirror;
    logic             r_done;
    logic             r_err;

    logic             w_accept;
    logic [WIDTH-1:0] w_up_t;
    logic [WIDTH-1:0] w_dn_t;
    logic [WIDTH-1:0] w_step_val;

    assign cmd_ready = (r_state == S_IDLE) & ~rst;
    assign w_accept  = cmd_valid & cmd_ready;
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign err       = r_err;
    assign q_mirror  = r_mirror;
    assign dbg_state = r_state;

    // Per-bit toggle enables for counting: a bit flips when all lower bits are 1 (up) or all 0 (down).
    always_comb begin
        logic v_all_one;
        logic v_all_zero;
        v_all_one  = 1'b1;
        v_all_zero = 1'b1;
        w_up_t     = '0;
        w_dn_t     = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_up_t[i]  = v_all_one;
            w_dn_t[i]  = v_all_zero;
            v_all_one  = v_all_one & r_mirror[i];
            v_all_zero = v_all_zero & ~r_mirror[i];
        end
    end

    // Next shadow value for one STEP edge, modulo 2^WIDTH.
    always_comb begin
        w_step_val = r_mirror;
        case (r_op)
            OP_UP:   w_step_val = r_mirror + WIDTH'(1);
            OP_DOWN: w_step_val = r_mirror - WIDTH'(1);
            default: w_step_val = r_mirror;
        endcase
    end

    // Bank drive decoded from the registered state; reset forces a clear on every edge.
    always_comb begin
        jk_j  = '0;
        jk_k  = '0;
        jk_pr = 1'b1;
        jk_cl = 1'b1;
        case (r_state)
            S_CLR:  jk_cl = 1'b0;
            S_PRE:  jk_pr = 1'b0;
            S_LOAD: begin
                jk_j = r_data;
                jk_k = ~r_data;
            end
            S_TOG: begin
                jk_j = r_data;
                jk_k = r_data;
            end
            S_STEP: begin
                if (r_op == OP_UP) begin
                    jk_j = w_up_t;
                    jk_k = w_up_t;
                end else if (r_op == OP_DOWN) begin
                    jk_j = w_dn_t;
                    jk_k = w_dn_t;
                end
            end
            default: ;
        endcase
        if (rst) begin
            jk_j  = '0;
            jk_k  = '0;
            jk_pr = 1'b1;
            jk_cl = 1'b0;
        end
    end

    // Sequencer FSM with shadow state, done pulse and sticky mismatch flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_op     <= OP_NOP;
            r_data   <= '0;
            r_cnt    <= '0;
            r_mirror <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            // A CLEAR accept wins over a mismatch seen on the same edge.
            if (w_accept && (cmd_op == OP_CLEAR)) begin
                r_err <= 1'b0;
            end else if (q_fb != r_mirror) begin
                r_err <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op   <= cmd_op;
                        r_data <= cmd_data;
                        r_cnt  <= cmd_cnt;
                        case (cmd_op)
                            OP_CLEAR:  r_state <= S_CLR;
                            OP_PRESET: r_state <= S_PRE;
                            OP_LOAD:   r_state <= S_LOAD;
                            OP_TOGGLE: r_state <= S_TOG;
                            OP_UP, OP_DOWN, OP_HOLD: begin
                                if (cmd_cnt == '0) begin
                                    r_done <= 1'b1;
                                end else begin
                                    r_state <= S_STEP;
                                end
                            end
                            default: r_done <= 1'b1;
                        endcase
                    end
                end
                S_CLR: begin
                    r_mirror <= '0;
                    r_state  <= S_IDLE;
                    r_done   <= 1'b1;
                end
                S_PRE: begin
                    r_mirror <= '1;
                    r_state  <= S_IDLE;
                    r_done   <= 1'b1;
                end
                S_LOAD: begin
                    r_mirror <= r_data;
                    r_state  <= S_IDLE;
                    r_done   <= 1'b1;
                end
                S_TOG: begin
                    r_mirror <= r_mirror ^ r_data;
                    r_state  <= S_IDLE;
                    r_done   <= 1'b1;
                end
                S_STEP: begin
                    r_mirror <= w_step_val;
                    r_cnt    <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jkff_bank_ctrl.sv
// tb_jkff_bank_ctrl: drives jkff_bank_ctrl against a behavioural bank of four
// jk flip-flops and a command-level reference model of the bank contents.
module tb_jkff_bank_ctrl;

    localparam int WIDTH = 4;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic [CNT_W-1:0] cmd_cnt;
    logic [WIDTH-1:0] jk_j;
    logic [WIDTH-1:0] jk_k;
    logic             jk_pr;
    logic             jk_cl;
    logic [WIDTH-1:0] q_fb;
    logic [WIDTH-1:0] q_mirror;
    logic             busy;
    logic             done;
    logic             err;
    logic [2:0]       dbg_state;

    logic [WIDTH-1:0] bank_q;
    logic [WIDTH-1:0] fb_flip;

    int               n_cmp;
    int               n_fail;
    logic [WIDTH-1:0] model_q;
    logic             model_err;
    logic [WIDTH-1:0] exp_q[$];

    jkff_bank_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_cnt(cmd_cnt),
        .jk_j(jk_j), .jk_k(jk_k), .jk_pr(jk_pr), .jk_cl(jk_cl),
        .q_fb(q_fb), .q_mirror(q_mirror),
        .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bank of jk cells: synchronous active-low clear (highest priority) and preset.
    always @(posedge clk) begin
        for (int i = 0; i < WIDTH; i++) begin
            if (!jk_cl)                         bank_q[i] <= 1'b0;
            else if (!jk_pr)                    bank_q[i] <= 1'b1;
            else if (jk_j[i] && jk_k[i])        bank_q[i] <= ~bank_q[i];
            else if (jk_j[i])                   bank_q[i] <= 1'b1;
            else if (jk_k[i])                   bank_q[i] <= 1'b0;
        end
    end
    assign q_fb = bank_q ^ fb_flip;

    // Reference model: bank contents after one bank edge of a command.
    function automatic logic [WIDTH-1:0] model_next(input logic [2:0] op, input logic [WIDTH-1:0] d,
                                                    input logic [WIDTH-1:0] q);
        int v;
        v = int'(q);
        case (op)
            3'd1: v = 0;
            3'd2: v = (1 << WIDTH) - 1;
            3'd3: v = int'(d);
            3'd4: v = (v + 1) % (1 << WIDTH);
            3'd5: v = (v + (1 << WIDTH) - 1) % (1 << WIDTH);
            3'd6: v = v ^ int'(d);
            default: v = v;
        endcase
        return v[WIDTH-1:0];
    endfunction

    // Expected j: LOAD sets data bits, TOGGLE flips data bits, counting flips exactly the bits that change.
    function automatic logic [WIDTH-1:0] model_j(input logic [2:0] op, input logic [WIDTH-1:0] d,
                                                 input logic [WIDTH-1:0] q);
        if (op == 3'd3 || op == 3'd6) return d;
        if (op == 3'd4 || op == 3'd5) return model_next(op, d, q) ^ q;
        return '0;
    endfunction

    function automatic logic [WIDTH-1:0] model_k(input logic [2:0] op, input logic [WIDTH-1:0] d,
                                                 input logic [WIDTH-1:0] q);
        if (op == 3'd3) return ~d;
        if (op == 3'd6) return d;
        if (op == 3'd4 || op == 3'd5) return model_next(op, d, q) ^ q;
        return '0;
    endfunction

    // Driver: offer one command at the current negedge, follow it to its done cycle.
    // Returns positioned at the done negedge so the next command can go back to back.
    task automatic run_cmd(input logic [2:0] op, input logic [WIDTH-1:0] d, input logic [CNT_W-1:0] cnt);
        int               n;
        logic [WIDTH-1:0] q_before;
        logic [WIDTH-1:0] q_after;
        if (op == 3'd1 || op == 3'd2 || op == 3'd3 || op == 3'd6) n = 1;
        else if (op == 3'd0) n = 0;
        else n = int'(cnt);
        exp_q.delete();
        q_before = model_q;
        for (int s = 0; s < n; s++) begin
            q_before = model_next(op, d, q_before);
            exp_q.push_back(q_before);
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        cmd_cnt   = cnt;
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_ready op=%0d: got %b expected 1", op, cmd_ready);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 3'($urandom);
        cmd_data  = WIDTH'($urandom);
        cmd_cnt   = CNT_W'($urandom);
        if (op == 3'd1) model_err = 1'b0;
        if (n == 0) begin
            n_cmp++;
            if ({busy, done, q_mirror} !== {1'b0, 1'b1, model_q}) begin
                n_fail++;
                $display("FAIL zero_step op=%0d: got busy/done/q %b/%b/%h expected 0/1/%h",
                         op, busy, done, q_mirror, model_q);
            end
            return;
        end
        while (exp_q.size() > 0) begin
            q_after = exp_q.pop_front();
            n_cmp++;
            if ({busy, done, q_mirror, err} !== {1'b1, 1'b0, model_q, model_err}) begin
                n_fail++;
                $display("FAIL step_status op=%0d: got busy/done/q/err %b/%b/%h/%b expected 1/0/%h/%b",
                         op, busy, done, q_mirror, err, model_q, model_err);
            end
            n_cmp++;
            if ({jk_j, jk_k, jk_pr, jk_cl} !== {model_j(op, d, model_q), model_k(op, d, model_q),
                                                op != 3'd2, op != 3'd1}) begin
                n_fail++;
                $display("FAIL bank_drive op=%0d q=%h: got j/k/pr/cl %h/%h/%b/%b expected %h/%h/%b/%b",
                         op, model_q, jk_j, jk_k, jk_pr, jk_cl, model_j(op, d, model_q),
                         model_k(op, d, model_q), op != 3'd2, op != 3'd1);
            end
            model_q = q_after;
            @(negedge clk);
        end
        n_cmp++;
        if ({busy, done, q_mirror, q_fb, err} !== {1'b0, 1'b1, model_q, model_q, model_err}) begin
            n_fail++;
            $display("FAIL cmd_done op=%0d: got busy/done/q/fb/err %b/%b/%h/%h/%b expected 0/1/%h/%h/%b",
                     op, busy, done, q_mirror, q_fb, err, model_q, model_q, model_err);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_data  = '0;
        cmd_cnt   = '0;
        fb_flip   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({jk_cl, jk_pr, q_fb, q_mirror, cmd_ready, busy, done} !== {1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: got cl/pr/fb/q/rdy/busy/done %b/%b/%h/%h/%b/%b/%b expected 0/1/0/0/0/0/0",
                     jk_cl, jk_pr, q_fb, q_mirror, cmd_ready, busy, done);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({cmd_ready, err, jk_cl} !== 3'b101) begin
            n_fail++;
            $display("FAIL reset_release: got rdy/err/cl %b/%b/%b expected 1/0/1", cmd_ready, err, jk_cl);
        end
        model_q   = '0;
        model_err = 1'b0;
    endtask

    task automatic test_load();
        run_cmd(3'd3, 4'b1010, '0);
        @(negedge clk);
        n_cmp++;
        if ({done, busy, q_fb} !== {1'b0, 1'b0, 4'b1010}) begin
            n_fail++;
            $display("FAIL load_single_pulse: got done/busy/fb %b/%b/%h expected 0/0/a", done, busy, q_fb);
        end
    endtask

    task automatic test_up_wrap();
        run_cmd(3'd3, 4'b1110, '0);
        run_cmd(3'd4, '0, 8'd3);
        n_cmp++;
        if ({q_fb, err} !== {4'b0001, 1'b0}) begin
            n_fail++;
            $display("FAIL up_wrap_final: got fb/err %h/%b expected 1/0", q_fb, err);
        end
    endtask

    task automatic test_down_toggle_hold();
        run_cmd(3'd1, '0, '0);
        run_cmd(3'd5, '0, 8'd2);
        run_cmd(3'd6, 4'b0101, '0);
        n_cmp++;
        if (q_fb !== 4'b1011) begin
            n_fail++;
            $display("FAIL toggle_result: got %h expected b", q_fb);
        end
        run_cmd(3'd7, '0, 8'd4);
        run_cmd(3'd0, '0, '0);
        run_cmd(3'd4, '0, 8'd0);
    endtask

    task automatic test_err_flag();
        @(negedge clk);
        fb_flip = 4'b0001;
        @(negedge clk);
        fb_flip = 4'b0000;
        model_err = 1'b1;
        n_cmp++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_set: got %b expected 1", err);
        end
        run_cmd(3'd3, WIDTH'($urandom), '0);
        run_cmd(3'd2, '0, '0);
        run_cmd(3'd1, '0, '0);
        n_cmp++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_cleared: got %b expected 0", err);
        end
    endtask

    task automatic test_reset_mid_cmd();
        run_cmd(3'd1, '0, '0);
        cmd_valid = 1'b1;
        cmd_op    = 3'd4;
        cmd_cnt   = 8'd10;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++;
        if ({busy, q_mirror} !== {1'b1, 4'd4}) begin
            n_fail++;
            $display("FAIL mid_progress: got busy/q %b/%h expected 1/4", busy, q_mirror);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({q_mirror, busy, cmd_ready, done, jk_cl} !== {4'h0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL mid_abort: got q/busy/rdy/done/cl %h/%b/%b/%b/%b expected 0/0/0/0/0",
                     q_mirror, busy, cmd_ready, done, jk_cl);
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({done, q_fb} !== {1'b0, 4'h0}) begin
                n_fail++;
                $display("FAIL abort_no_done cyc=%0d: got done/fb %b/%h expected 0/0", c, done, q_fb);
            end
        end
        rst       = 1'b0;
        model_q   = '0;
        model_err = 1'b0;
        #1;
        run_cmd(3'd3, WIDTH'($urandom), '0);
    endtask

    task automatic test_random();
        logic [2:0] op;
        for (int t = 0; t < 40; t++) begin
            op = 3'($urandom_range(0, 7));
            run_cmd(op, WIDTH'($urandom), CNT_W'($urandom_range(0, 5)));
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_load();
        test_up_wrap();
        test_down_toggle_hold();
        test_err_flag();
        test_reset_mid_cmd();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
